// File: rtl/wrapper_drq_pkg.sv
// Shared types and constants for the DMA-request handshake wrapper:
// channel FSM states, register map offsets and the unmapped-read pattern.
package wrapper_drq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_COOL   = 2'd3
  } ch_state_e;

  localparam int unsigned ADDR_STATUS     = 32'h000;
  localparam int unsigned ADDR_ERR        = 32'h004;
  localparam int unsigned ADDR_CNT_CLR    = 32'h008;
  localparam int unsigned ADDR_CNT_BASE   = 32'h010;
  localparam int unsigned ADDR_CNT_STRIDE = 32'h004;

  localparam int unsigned CNT_W = 16;

  localparam logic [31:0] RDATA_DEFAULT = 32'h0BAD_0BAD;

endpackage

// File: rtl/wrapper_drq_ch_fsm.sv
// One DMA request channel: IDLE/REQ/ACTIVE/COOL handshake, wrapping done counter
// and, when WRAPPER_DRQ_TIMEOUT_EN is defined, a REQ-state watchdog with sticky error.
module wrapper_drq_ch_fsm
  import wrapper_drq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             i_drq,
  input  logic             i_active,
  input  logic             i_done,
  input  logic             i_cnt_clr,
  input  logic             i_err_clr,
  output logic             o_dma_req,
  output logic             o_busy,
  output logic             o_err,
  output logic [CNT_W-1:0] o_cnt
);

  ch_state_e        r_state;
  ch_state_e        w_state_nxt;
  logic             r_dma_req;
  logic [CNT_W-1:0] r_cnt;
  logic             w_inc;
  logic             w_timeout;

`ifdef WRAPPER_DRQ_TIMEOUT_EN
  logic [7:0] r_wd;
  logic       r_err;

  // Counts cycles spent in REQ; holds zero everywhere else so each entry starts fresh.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_wd <= '0;
    end else if (r_state != ST_REQ) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + 8'd1;
    end
  end

  assign w_timeout = (r_state == ST_REQ) && !i_active && !i_done &&
                     ((r_wd + 8'd1) == 8'(TIMEOUT_CYCLES));

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end else if (i_err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign o_err = r_err;
`else
  logic w_unused_wd;

  assign w_unused_wd = i_err_clr ^ (TIMEOUT_CYCLES > 0);
  assign w_timeout   = 1'b0;
  assign o_err       = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_inc       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_drq) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (i_done) begin
          w_state_nxt = ST_COOL;
          w_inc       = 1'b1;
        end else if (i_active) begin
          w_state_nxt = ST_ACTIVE;
        end else if (w_timeout) begin
          w_state_nxt = ST_COOL;
        end
      end
      ST_ACTIVE: begin
        if (i_done) begin
          w_state_nxt = ST_COOL;
          w_inc       = 1'b1;
        end
      end
      ST_COOL: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // dma_req is a flop of the next-state decode so it is glitch-free toward the controller.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state   <= ST_IDLE;
      r_dma_req <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dma_req <= (w_state_nxt == ST_REQ);
    end
  end

  // A clear in the same cycle as a completion wins.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_inc) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_dma_req = r_dma_req;
  assign o_busy    = (r_state != ST_IDLE);
  assign o_cnt     = r_cnt;

endmodule

// File: rtl/wrapper_drq_handshake.sv
// Register front-end for NUM_CH DMA request channels: write decode and combinational
// read mux. Optional watchdog per channel is enabled by WRAPPER_DRQ_TIMEOUT_EN.
module wrapper_drq_handshake
  import wrapper_drq_pkg::*;
#(
  parameter int ADDRWIDTH      = 12,
  parameter int DATAWIDTH      = 32,
  parameter int NUM_CH         = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic                 read_en,
  input  logic                 write_en,
  input  logic [DATAWIDTH-1:0] wdata,
  output logic [DATAWIDTH-1:0] rdata,
  input  logic [NUM_CH-1:0]    drq_ch,
  output logic [NUM_CH-1:0]    dma_req,
  input  logic [NUM_CH-1:0]    dma_active,
  input  logic [NUM_CH-1:0]    dma_done,
  output logic                 err_irq
);

  logic                        w_wr_err;
  logic                        w_wr_clr;
  logic [NUM_CH-1:0]           w_err_clr;
  logic [NUM_CH-1:0]           w_cnt_clr;
  logic [NUM_CH-1:0]           w_busy;
  logic [NUM_CH-1:0]           w_err;
  logic [NUM_CH-1:0][CNT_W-1:0] w_cnt;
  logic                        w_unused_wdata;

  assign w_wr_err       = write_en && (addr == ADDRWIDTH'(ADDR_ERR));
  assign w_wr_clr       = write_en && (addr == ADDRWIDTH'(ADDR_CNT_CLR));
  assign w_err_clr      = w_wr_err ? wdata[NUM_CH-1:0] : '0;
  assign w_cnt_clr      = w_wr_clr ? wdata[NUM_CH-1:0] : '0;
  assign w_unused_wdata = ^wdata;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    wrapper_drq_ch_fsm #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ch (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .i_drq     (drq_ch[g]),
      .i_active  (dma_active[g]),
      .i_done    (dma_done[g]),
      .i_cnt_clr (w_cnt_clr[g]),
      .i_err_clr (w_err_clr[g]),
      .o_dma_req (dma_req[g]),
      .o_busy    (w_busy[g]),
      .o_err     (w_err[g]),
      .o_cnt     (w_cnt[g])
    );
  end

  assign err_irq = |w_err;

  always_comb begin
    rdata = DATAWIDTH'(RDATA_DEFAULT);
    if (read_en) begin
      if (addr == ADDRWIDTH'(ADDR_STATUS)) begin
        rdata = DATAWIDTH'(w_busy);
      end else if (addr == ADDRWIDTH'(ADDR_ERR)) begin
        rdata = DATAWIDTH'(w_err);
      end else if (addr == ADDRWIDTH'(ADDR_CNT_CLR)) begin
        rdata = '0;
      end else begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          if (addr == ADDRWIDTH'(ADDR_CNT_BASE + ADDR_CNT_STRIDE * ch)) begin
            rdata = DATAWIDTH'(w_cnt[ch]);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wrapper_drq_handshake.sv
// Randomized self-checking bench for wrapper_drq_handshake; expected values come from
// transfer timing arithmetic and a per-channel done-count array.
module tb_wrapper_drq_handshake;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int NCH = 5;
`ifdef WRAPPER_DRQ_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 255;
`endif

  localparam logic [AW-1:0] A_STATUS = 12'h000;
  localparam logic [AW-1:0] A_ERR    = 12'h004;
  localparam logic [AW-1:0] A_CLR    = 12'h008;
  localparam logic [DW-1:0] BAD      = 32'h0BAD0BAD;

  logic           hclk = 1'b0;
  logic           hresetn;
  logic [AW-1:0]  addr;
  logic           read_en, write_en;
  logic [DW-1:0]  wdata, rdata;
  logic [NCH-1:0] drq_ch, dma_req, dma_active, dma_done;
  logic           err_irq;

  int n_cmp  = 0;
  int n_fail = 0;
  int unsigned model_cnt [NCH];

  logic [NCH-1:0] obs_req  [0:63];
  logic [NCH-1:0] obs_stat [0:63];
  bit             obs_skip [0:63];
  int             obs_n;
  logic [DW-1:0]  v;

  wrapper_drq_handshake #(
    .ADDRWIDTH(AW), .DATAWIDTH(DW), .NUM_CH(NCH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .addr(addr), .read_en(read_en),
    .write_en(write_en), .wdata(wdata), .rdata(rdata), .drq_ch(drq_ch),
    .dma_req(dma_req), .dma_active(dma_active), .dma_done(dma_done),
    .err_irq(err_irq)
  );

  always #5 hclk = ~hclk;

  function automatic logic [NCH-1:0] one(input int ch);
    logic [NCH-1:0] r;
    r = '0;
    r[ch] = 1'b1;
    return r;
  endfunction

  function automatic logic [AW-1:0] cnt_addr(input int ch);
    return AW'(16 + 4 * ch);
  endfunction

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic clear_inputs;
    drq_ch = '0; dma_active = '0; dma_done = '0;
    read_en = 1'b0; write_en = 1'b0; wdata = '0; addr = '0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
    addr = a;
    read_en = 1'b1;
    #1;
    d = rdata;
    read_en = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr = a; wdata = d; write_en = 1'b1;
    tick();
    write_en = 1'b0; wdata = '0;
  endtask

  // Cycle 0: drq sampled in IDLE. dma_active[ch] held from cycle k to k+b, dma_done[ch]
  // pulses at cycle k+b. Optional CNT_CLR write lands in the done cycle. Spurious dones
  // hit the channel in IDLE and COOL; other channels get random active/done noise.
  task automatic do_xfer(input int ch, input int k, input int b, input bit hold,
                         input logic [NCH-1:0] clr);
    int d;
    d = k + b;
    obs_n = d + 2;
    for (int c = 0; c <= d + 1; c++) begin
      drq_ch = (hold || c == 0) ? one(ch) : '0;
      dma_active = '0; dma_done = '0; write_en = 1'b0;
      for (int o = 0; o < NCH; o++) begin
        if (o != ch) begin
          dma_active[o] = 1'($urandom_range(0, 1));
          dma_done[o]   = 1'($urandom_range(0, 1));
        end
      end
      if (c >= k && c <= d) dma_active[ch] = 1'b1;
      if (c == d) dma_done[ch] = 1'b1;
      else if (c == 0 || c == d + 1) dma_done[ch] = 1'($urandom_range(0, 1));
      if (c == d && clr != '0) begin
        addr = A_CLR; wdata = DW'(clr); write_en = 1'b1;
      end
      #2;
      obs_req[c]  = dma_req;
      obs_skip[c] = write_en;
      if (!write_en) begin
        rd(A_STATUS, v);
        obs_stat[c] = v[NCH-1:0];
      end else begin
        obs_stat[c] = '0;
      end
      tick();
    end
    write_en = 1'b0; wdata = '0; dma_active = '0; dma_done = '0;
    if (!hold) drq_ch = '0;
    for (int o = 0; o < NCH; o++) begin
      if (clr[o]) model_cnt[o] = 0;
      else if (o == ch) model_cnt[o] = (model_cnt[o] + 1) & 32'hFFFF;
    end
  endtask

  task automatic test_reset;
    clear_inputs();
    hresetn = 1'b0;
    repeat (3) @(posedge hclk);
    #1;
    n_cmp++;
    if (dma_req !== '0) begin n_fail++; $display("FAIL reset_dma_req got %b expected 0", dma_req); end
    n_cmp++;
    if (err_irq !== 1'b0) begin n_fail++; $display("FAIL reset_err_irq got %b expected 0", err_irq); end
    rd(A_STATUS, v);
    n_cmp++;
    if (v !== '0) begin n_fail++; $display("FAIL reset_status got %h expected 0", v); end
    rd(A_ERR, v);
    n_cmp++;
    if (v !== '0) begin n_fail++; $display("FAIL reset_err got %h expected 0", v); end
    for (int ch = 0; ch < NCH; ch++) begin
      model_cnt[ch] = 0;
      rd(cnt_addr(ch), v);
      n_cmp++;
      if (v !== '0) begin n_fail++; $display("FAIL reset_cnt%0d got %h expected 0", ch, v); end
    end
    hresetn = 1'b1;
    tick();
  endtask

  task automatic test_regmap;
    logic [AW-1:0] bad_a [5];
    bad_a = '{12'h00C, 12'h024, 12'hFFC, 12'h001, 12'h110};
    addr = A_STATUS; read_en = 1'b0;
    #1;
    n_cmp++;
    if (rdata !== BAD) begin n_fail++; $display("FAIL read_en_low got %h expected %h", rdata, BAD); end
    for (int i = 0; i < 5; i++) begin
      rd(bad_a[i], v);
      n_cmp++;
      if (v !== BAD) begin n_fail++; $display("FAIL unmapped_%h got %h expected %h", bad_a[i], v, BAD); end
    end
    rd(A_CLR, v);
    n_cmp++;
    if (v !== '0) begin n_fail++; $display("FAIL cnt_clr_read got %h expected 0", v); end
    tick();
  endtask

  task automatic test_single;
    logic [NCH-1:0] e;
    do_xfer(0, 3, 3, 1'b0, '0);
    for (int c = 0; c < obs_n; c++) begin
      e = (c >= 1 && c <= 3) ? one(0) : '0;
      n_cmp++;
      if (obs_req[c] !== e) begin n_fail++; $display("FAIL single_req c%0d got %b expected %b", c, obs_req[c], e); end
      e = (c >= 1 && c <= 7) ? one(0) : '0;
      n_cmp++;
      if (obs_stat[c] !== e) begin n_fail++; $display("FAIL single_status c%0d got %b expected %b", c, obs_stat[c], e); end
    end
    #2;
    rd(A_STATUS, v);
    n_cmp++;
    if (v !== '0) begin n_fail++; $display("FAIL single_status_c8 got %h expected 0", v); end
    rd(cnt_addr(0), v);
    n_cmp++;
    if (v !== DW'(model_cnt[0])) begin n_fail++; $display("FAIL single_cnt0 got %h expected %h", v, model_cnt[0]); end
    tick();
  endtask

  task automatic test_simultaneous;
    logic [NCH-1:0] e;
    do_xfer(1, 2, 0, 1'b0, '0);
    for (int c = 0; c < obs_n; c++) begin
      e = (c >= 1 && c <= 2) ? one(1) : '0;
      n_cmp++;
      if (obs_req[c] !== e) begin n_fail++; $display("FAIL simul_req c%0d got %b expected %b", c, obs_req[c], e); end
      e = (c >= 1 && c <= 3) ? one(1) : '0;
      n_cmp++;
      if (obs_stat[c] !== e) begin n_fail++; $display("FAIL simul_status c%0d got %b expected %b", c, obs_stat[c], e); end
    end
    rd(cnt_addr(1), v);
    n_cmp++;
    if (v !== DW'(model_cnt[1])) begin n_fail++; $display("FAIL simul_cnt1 got %h expected %h", v, model_cnt[1]); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [NCH-1:0] e;
    int k, b;
    model_cnt[2] = model_cnt[2];
    for (int t = 0; t < 2; t++) begin
      k = $urandom_range(1, 4);
      b = $urandom_range(0, 3);
      do_xfer(2, k, b, 1'b1, '0);
      for (int c = 0; c < obs_n; c++) begin
        e = (c >= 1 && c <= k) ? one(2) : '0;
        n_cmp++;
        if (obs_req[c] !== e) begin n_fail++; $display("FAIL b2b%0d_req c%0d got %b expected %b", t, c, obs_req[c], e); end
        e = (c >= 1 && c <= k + b + 1) ? one(2) : '0;
        n_cmp++;
        if (obs_stat[c] !== e) begin n_fail++; $display("FAIL b2b%0d_status c%0d got %b expected %b", t, c, obs_stat[c], e); end
      end
    end
    drq_ch = '0;
    #2;
    rd(A_STATUS, v);
    n_cmp++;
    if (v !== '0) begin n_fail++; $display("FAIL b2b_idle_status got %h expected 0", v); end
    rd(cnt_addr(2), v);
    n_cmp++;
    if (v !== DW'(model_cnt[2])) begin n_fail++; $display("FAIL b2b_cnt2 got %h expected %h", v, model_cnt[2]); end
    tick();
  endtask

  task automatic test_random;
    for (int it = 0; it < 24; it++) begin
      int ch, k, b;
      logic [NCH-1:0] clr, e, mask;
      ch  = $urandom_range(0, NCH - 1);
      k   = $urandom_range(1, 4);
      b   = $urandom_range(0, 3);
      clr = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      do_xfer(ch, k, b, 1'b0, clr);
      for (int c = 0; c < obs_n; c++) begin
        e = (c >= 1 && c <= k) ? one(ch) : '0;
        n_cmp++;
        if (obs_req[c] !== e) begin n_fail++; $display("FAIL rnd%0d_req c%0d got %b expected %b", it, c, obs_req[c], e); end
        if (!obs_skip[c]) begin
          e = (c >= 1 && c <= k + b + 1) ? one(ch) : '0;
          n_cmp++;
          if (obs_stat[c] !== e) begin n_fail++; $display("FAIL rnd%0d_status c%0d got %b expected %b", it, c, obs_stat[c], e); end
        end
      end
      rd(cnt_addr(ch), v);
      n_cmp++;
      if (v !== DW'(model_cnt[ch])) begin n_fail++; $display("FAIL rnd%0d_cnt%0d got %h expected %h", it, ch, v, model_cnt[ch]); end
      if ($urandom_range(0, 4) == 0) begin
        mask = NCH'($urandom);
        wr(A_CLR, DW'(mask));
        for (int o = 0; o < NCH; o++) if (mask[o]) model_cnt[o] = 0;
      end
    end
    #2;
    for (int ch = 0; ch < NCH; ch++) begin
      rd(cnt_addr(ch), v);
      n_cmp++;
      if (v !== DW'(model_cnt[ch])) begin n_fail++; $display("FAIL rnd_final_cnt%0d got %h expected %h", ch, v, model_cnt[ch]); end
    end
    tick();
  endtask

  task automatic test_timeout;
`ifdef WRAPPER_DRQ_TIMEOUT_EN
    for (int c = 0; c <= 12; c++) begin
      drq_ch = (c == 0) ? one(4) : '0;
      #2;
      n_cmp++;
      if (dma_req[4] !== (c >= 1 && c <= 10)) begin n_fail++; $display("FAIL to_req c%0d got %b", c, dma_req[4]); end
      n_cmp++;
      if (err_irq !== (c >= 11)) begin n_fail++; $display("FAIL to_irq c%0d got %b", c, err_irq); end
      tick();
    end
    rd(A_ERR, v);
    n_cmp++;
    if (v !== 32'h10) begin n_fail++; $display("FAIL to_err got %h expected 10", v); end
    rd(cnt_addr(4), v);
    n_cmp++;
    if (v !== DW'(model_cnt[4])) begin n_fail++; $display("FAIL to_cnt4 got %h expected %h", v, model_cnt[4]); end
    wr(A_ERR, 32'h01);
    rd(A_ERR, v);
    n_cmp++;
    if (v !== 32'h10) begin n_fail++; $display("FAIL to_err_wrongbit got %h expected 10", v); end
    tick();
    wr(A_ERR, 32'h10);
    rd(A_ERR, v);
    n_cmp++;
    if (v !== '0) begin n_fail++; $display("FAIL to_err_clr got %h expected 0", v); end
    n_cmp++;
    if (err_irq !== 1'b0) begin n_fail++; $display("FAIL to_irq_clr got %b expected 0", err_irq); end
`else
    for (int c = 0; c <= 22; c++) begin
      drq_ch   = (c == 0) ? one(4) : '0;
      dma_done = (c == 21) ? one(4) : '0;
      #2;
      n_cmp++;
      if (dma_req[4] !== (c >= 1 && c <= 21)) begin n_fail++; $display("FAIL nowd_req c%0d got %b", c, dma_req[4]); end
      n_cmp++;
      if (err_irq !== 1'b0) begin n_fail++; $display("FAIL nowd_irq c%0d got %b expected 0", c, err_irq); end
      if (c == 15) begin
        rd(A_ERR, v);
        n_cmp++;
        if (v !== '0) begin n_fail++; $display("FAIL nowd_err got %h expected 0", v); end
      end
      tick();
    end
    dma_done = '0;
    model_cnt[4] = (model_cnt[4] + 1) & 32'hFFFF;
    wr(A_ERR, 32'h1F);
    rd(A_ERR, v);
    n_cmp++;
    if (v !== '0) begin n_fail++; $display("FAIL nowd_err_w got %h expected 0", v); end
    rd(cnt_addr(4), v);
    n_cmp++;
    if (v !== DW'(model_cnt[4])) begin n_fail++; $display("FAIL nowd_cnt4 got %h expected %h", v, model_cnt[4]); end
`endif
    tick();
  endtask

  task automatic test_wrap;
    force dut.g_ch[3].u_ch.r_cnt = 16'hFFFF;
    #1;
    release dut.g_ch[3].u_ch.r_cnt;
    model_cnt[3] = 32'hFFFF;
    rd(cnt_addr(3), v);
    n_cmp++;
    if (v !== 32'hFFFF) begin n_fail++; $display("FAIL wrap_preload got %h expected ffff", v); end
    tick();
    do_xfer(3, 1, 1, 1'b0, '0);
    rd(cnt_addr(3), v);
    n_cmp++;
    if (v !== DW'(model_cnt[3])) begin n_fail++; $display("FAIL wrap_cnt3 got %h expected %h", v, model_cnt[3]); end
    tick();
    do_xfer(3, 2, 1, 1'b0, '0);
    rd(cnt_addr(3), v);
    n_cmp++;
    if (v !== DW'(model_cnt[3])) begin n_fail++; $display("FAIL wrap_plus1 got %h expected %h", v, model_cnt[3]); end
    tick();
    do_xfer(3, 1, 2, 1'b0, 5'h08);
    rd(cnt_addr(3), v);
    n_cmp++;
    if (v !== DW'(model_cnt[3])) begin n_fail++; $display("FAIL clr_race got %h expected %h", v, model_cnt[3]); end
    tick();
  endtask

  task automatic test_reset_mid;
    drq_ch = one(0);
    tick();
    drq_ch = '0;
    #2;
    n_cmp++;
    if (dma_req !== one(0)) begin n_fail++; $display("FAIL rstmid_pre_req got %b expected %b", dma_req, one(0)); end
    hresetn = 1'b0;
    #1;
    n_cmp++;
    if (dma_req !== '0) begin n_fail++; $display("FAIL rstmid_req_async got %b expected 0", dma_req); end
    tick();
    hresetn = 1'b1;
    for (int ch = 0; ch < NCH; ch++) model_cnt[ch] = 0;
    tick();
    drq_ch = one(0);
    tick();
    drq_ch = '0; dma_active = one(0);
    tick();
    #2;
    rd(A_STATUS, v);
    n_cmp++;
    if (v !== DW'(one(0))) begin n_fail++; $display("FAIL rstmid_active_status got %h expected 1", v); end
    hresetn = 1'b0;
    #1;
    n_cmp++;
    if (dma_req !== '0) begin n_fail++; $display("FAIL rstmid_active_req got %b expected 0", dma_req); end
    rd(A_STATUS, v);
    n_cmp++;
    if (v !== '0) begin n_fail++; $display("FAIL rstmid_status got %h expected 0", v); end
    dma_done = one(0);
    tick();
    dma_done = '0; dma_active = '0;
    hresetn = 1'b1;
    tick();
    for (int ch = 0; ch < NCH; ch++) begin
      rd(cnt_addr(ch), v);
      n_cmp++;
      if (v !== DW'(model_cnt[ch])) begin n_fail++; $display("FAIL rstmid_cnt%0d got %h expected %h", ch, v, model_cnt[ch]); end
    end
    n_cmp++;
    if (err_irq !== 1'b0) begin n_fail++; $display("FAIL rstmid_irq got %b expected 0", err_irq); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_regmap();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_timeout();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
